vga_fb_reader: RTL
==================

# vga_fb_reader

Display-side frame buffer reader for the VGA controller. It takes active-video and sync strobes from the VGA timing generator and drives the read port (port B) of the dual-port frame buffer BRAM. It upscales a FB_W x FB_H buffer by an integer SCALE and outputs RGB with syncs realigned to the BRAM read latency. Port A remains free for the pixel writer.

## Interface
Parameters:
- COLR_W, 4, bits per colour channel; memory word is 3*COLR_W = {R,G,B}, with R in the MSBs.
- FB_W, 160, frame buffer pixels per line.
- FB_H, 120, frame buffer lines.
- SCALE, 4, integer replication factor, applied both horizontally and vertically; must be ≥1.
- ADDR_W, $clog2(FB_W*FB_H), BRAM address width.
- SYNC_POL, 0, active level of hsync_i/vsync_i and hsync_o/vsync_o.

Ports:
- clk  in  1  pixel clock, shared with the BRAM.
- rstn  in  1  asynchronous active-low reset.
- de_i  in  1  active-video strobe from the timing generator.
- hsync_i  in  1  horizontal sync.
- vsync_i  in  1  vertical sync.
- addr_o  out  ADDR_W  BRAM port-B address.
- en_o  out  1  BRAM port-B enable; port-B write enable is tied 0 at the top level.
- rdata_i  in  3*COLR_W  BRAM port-B data, registered in the BRAM with 1-cycle latency.
- r_o, g_o, b_o  out  COLR_W each  pixel colour.
- hsync_o, vsync_o  out  1  syncs delayed to align with colour.
- de_o  out  1  delayed active video.

## Operation
- FSM states:
  - WAIT_VS (reset state): en_o=0, addresses held at 0.
  - ARMED: entered while vsync_i is at SYNC_POL; counters cleared.
  - ACTIVE: entered on the first cycle vsync_i leaves SYNC_POL.
  - ACTIVE → ARMED whenever vsync_i returns to SYNC_POL.
- Counters:
  - x_sub: 0..SCALE-1.
  - y_sub: 0..SCALE-1.
  - line_base: ADDR_W bits.
  - cur_addr: ADDR_W bits.
- addr_o = cur_addr, combinational from the registers. en_o = de_i when in ACTIVE, otherwise 0.
- Each ACTIVE cycle with de_i=1:
  - If x_sub==SCALE-1: x_sub←0 and cur_addr←cur_addr+1.
  - Otherwise: x_sub←x_sub+1.
- End of line (de_i 1→0, detected by a registered de_i):
  - x_sub←0.
  - If y_sub==SCALE-1: y_sub←0, line_base←cur_addr.
  - Otherwise: y_sub←y_sub+1, cur_addr←line_base (the buffer line is repeated).
- Address wrap: cur_addr increments from FB_W*FB_H-1 to 0. A de_i window longer than FB_W*SCALE is not flagged; the address continues linearly.
- Simultaneous vsync_i at SYNC_POL and de_i falling edge: the vsync clear wins.
- While de_o=0, r_o/g_o/b_o are forced to 0 (blanking).
- Arithmetic is unsigned. line_base and cur_addr are ADDR_W bits; the increment truncates.

## Timing
- Reset values:
  - addr_o=0, en_o=0.
  - r_o=g_o=b_o=0, de_o=0.
  - hsync_o=vsync_o=~SYNC_POL.
  - FSM=WAIT_VS, all counters 0.
- Pipeline: inputs sampled at edge n; BRAM data valid after edge n+1; outputs registered at edge n+2. Total latency is 2 cycles for colour, de, hsync and vsync alike.
- Reset mid-frame: outputs blank and en_o=0 until the next vsync pulse completes. There are no partial-frame reads.
- The pipeline keeps streaming across de gaps and has no stall input.

## Configuration
- VGA_FB_TEST_PATTERN_EN:
  - Defined: en_o is held 0 and rdata_i is ignored. Colour is 8 vertical bars selected by output column/(FB_W*SCALE/8), in order white, yellow, cyan, green, magenta, red, blue, black (full-scale channels). Latency and sync alignment are unchanged.
  - Undefined: colour comes from BRAM as described above.

## Structure
- Package vga_fb_pkg contains:
  - Constants COLR_W, FB_W, FB_H, SCALE.
  - typedef rgb_t, a packed struct {r,g,b}.
  - typedef fb_state_t, an enum {WAIT_VS, ARMED, ACTIVE}.
  - The colour-bar lookup function.
- Sub-module vga_fb_addr_gen holds the FSM, x_sub/y_sub, line_base and cur_addr, and produces addr_o and en_o. The top level holds the 2-stage sync/de delay line and the output colour register.

## Test plan
- Reset, then a vsync pulse, then one de_i window of 640 cycles (FB_W=160, SCALE=4):
  - addr_o steps 0,0,0,0,1,…,159, each value held 4 cycles.
  - en_o high for exactly 640 cycles.
- Four consecutive lines:
  - Lines 0–3 all read 0..159.
  - Line 4 starts at 160.
  - Last line of the frame (row 479) reads 19040..19199, then wraps to 0 after the next vsync.
- BRAM preloaded with word=address[11:0]:
  - r_o/g_o/b_o equal the expected word exactly 2 cycles after the matching addr_o.
  - hsync_o and vsync_o equal their inputs delayed by 2.
  - Outputs are 0 during blanking.
- rstn pulsed low at mid-frame line 200:
  - All outputs go to reset values asynchronously.
  - en_o stays 0 until vsync completes.
  - The next frame starts at address 0.
- vsync_i asserted on the same cycle as a de_i falling edge: counters clear to 0, with no line_base update.
- VGA_FB_TEST_PATTERN_EN build:
  - Columns 0–79 output RGB=F,F,F.
  - Columns 560–639 output 0,0,0.
  - en_o is constantly 0.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared constants, types and the colour-bar lookup for the VGA frame buffer reader.
package vga_fb_pkg;

    localparam int COLR_W = 4;
    localparam int FB_W   = 160;
    localparam int FB_H   = 120;
    localparam int SCALE  = 4;

    typedef struct packed {
        logic [COLR_W-1:0] r;
        logic [COLR_W-1:0] g;
        logic [COLR_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {WAIT_VS, ARMED, ACTIVE} fb_state_t;

    // Returns {r,g,b} on/off for bar 0..7: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        logic [2:0] m;
        case (idx)
            3'd0:    m = 3'b111;
            3'd1:    m = 3'b110;
            3'd2:    m = 3'b011;
            3'd3:    m = 3'b010;
            3'd4:    m = 3'b101;
            3'd5:    m = 3'b100;
            3'd6:    m = 3'b001;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vga_fb_addr_gen.sv
// Frame-sync FSM and scaled read-address generator for frame buffer port B.
module vga_fb_addr_gen import vga_fb_pkg::*; #(
    parameter int FB_W     = vga_fb_pkg::FB_W,
    parameter int FB_H     = vga_fb_pkg::FB_H,
    parameter int SCALE    = vga_fb_pkg::SCALE,
    parameter int ADDR_W   = $clog2(FB_W*FB_H),
    parameter bit SYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              de_i,
    input  logic              vsync_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              active
);

    localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [SUB_W-1:0]  SUB_MAX = SUB_W'(SCALE-1);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(FB_W*FB_H-1);

    fb_state_t         state, state_nxt;
    logic              de_q;
    logic [SUB_W-1:0]  x_sub, x_nxt, y_sub, y_nxt;
    logic [ADDR_W-1:0] line_base, base_nxt, cur_addr, addr_nxt, addr_inc;
    logic              vs_act;

    assign vs_act   = (vsync_i == SYNC_POL);
    assign addr_inc = (cur_addr == LAST) ? '0 : cur_addr + 1'b1;
    assign addr_o   = cur_addr;
    assign active   = (state == ACTIVE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= WAIT_VS;
            de_q      <= 1'b0;
            x_sub     <= '0;
            y_sub     <= '0;
            line_base <= '0;
            cur_addr  <= '0;
        end else begin
            state     <= state_nxt;
            de_q      <= de_i;
            x_sub     <= x_nxt;
            y_sub     <= y_nxt;
            line_base <= base_nxt;
            cur_addr  <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x_sub;
        y_nxt     = y_sub;
        base_nxt  = line_base;
        addr_nxt  = cur_addr;
        case (state)
            WAIT_VS: if (vs_act) state_nxt = ARMED;
            ARMED: begin
                x_nxt    = '0;
                y_nxt    = '0;
                base_nxt = '0;
                addr_nxt = '0;
                if (!vs_act) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                // vsync clear takes priority over a coincident end of line
                if (vs_act) begin
                    state_nxt = ARMED;
                    x_nxt     = '0;
                    y_nxt     = '0;
                    base_nxt  = '0;
                    addr_nxt  = '0;
                end else if (de_i) begin
                    if (x_sub == SUB_MAX) begin
                        x_nxt    = '0;
                        addr_nxt = addr_inc;
                    end else begin
                        x_nxt = x_sub + 1'b1;
                    end
                end else if (de_q) begin
                    x_nxt = '0;
                    if (y_sub == SUB_MAX) begin
                        y_nxt    = '0;
                        base_nxt = cur_addr;
                    end else begin
                        y_nxt    = y_sub + 1'b1;
                        addr_nxt = line_base;
                    end
                end
            end
            default: state_nxt = WAIT_VS;
        endcase
    end

endmodule

// File: rtl/vga_fb_reader.sv
// Frame buffer port-B reader: scaled addressing, 2-cycle aligned colour/sync/de output.
// Define VGA_FB_TEST_PATTERN_EN to replace BRAM data with 8 vertical colour bars.
module vga_fb_reader import vga_fb_pkg::*; #(
    parameter int COLR_W   = vga_fb_pkg::COLR_W,
    parameter int FB_W     = vga_fb_pkg::FB_W,
    parameter int FB_H     = vga_fb_pkg::FB_H,
    parameter int SCALE    = vga_fb_pkg::SCALE,
    parameter int ADDR_W   = $clog2(FB_W*FB_H),
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  de_i,
    input  logic                  hsync_i,
    input  logic                  vsync_i,
    output logic [ADDR_W-1:0]     addr_o,
    output logic                  en_o,
    input  logic [3*COLR_W-1:0]   rdata_i,
    output logic [COLR_W-1:0]     r_o,
    output logic [COLR_W-1:0]     g_o,
    output logic [COLR_W-1:0]     b_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  de_o
);

    logic                active;
    logic                vis_d1, hs_d1, vs_d1;
    logic [3*COLR_W-1:0] pix, rgb_q;

    vga_fb_addr_gen #(
        .FB_W(FB_W), .FB_H(FB_H), .SCALE(SCALE), .ADDR_W(ADDR_W), .SYNC_POL(SYNC_POL)
    ) u_addr_gen (
        .clk(clk), .rstn(rstn), .de_i(de_i), .vsync_i(vsync_i),
        .addr_o(addr_o), .active(active)
    );

    // Video is only shown for frames that started cleanly after a full vsync pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vis_d1  <= 1'b0;
            hs_d1   <= ~SYNC_POL;
            vs_d1   <= ~SYNC_POL;
            de_o    <= 1'b0;
            hsync_o <= ~SYNC_POL;
            vsync_o <= ~SYNC_POL;
            rgb_q   <= '0;
        end else begin
            vis_d1  <= de_i & active;
            hs_d1   <= hsync_i;
            vs_d1   <= vsync_i;
            de_o    <= vis_d1;
            hsync_o <= hs_d1;
            vsync_o <= vs_d1;
            rgb_q   <= vis_d1 ? pix : '0;
        end
    end

`ifdef VGA_FB_TEST_PATTERN_EN
    localparam int COL_W = $clog2(FB_W*SCALE) + 1;
    localparam int BAR_W = (FB_W*SCALE/8 > 0) ? FB_W*SCALE/8 : 1;

    logic [COL_W-1:0] col;
    logic [2:0]       bar, mask;
    logic             unused;

    assign unused = ^rdata_i;
    assign en_o   = 1'b0;

    // col is the output column of the pixel currently in stage 1; saturates on overlong lines
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)           col <= '0;
        else if (!vis_d1)    col <= '0;
        else if (col != '1)  col <= col + 1'b1;
    end

    always_comb begin
        bar  = ((int'(col) / BAR_W) > 7) ? 3'd7 : 3'(int'(col) / BAR_W);
        mask = bar_mask(bar);
        pix  = {{COLR_W{mask[2]}}, {COLR_W{mask[1]}}, {COLR_W{mask[0]}}};
    end
`else
    assign en_o = de_i & active;
    assign pix  = rdata_i;
`endif

    assign r_o = rgb_q[3*COLR_W-1:2*COLR_W];
    assign g_o = rgb_q[2*COLR_W-1:COLR_W];
    assign b_o = rgb_q[COLR_W-1:0];

endmodule
